// File: rtl/spike_scheduler.sv
// Clocked spike scheduler between stimulus/readout logic and the self-timed req/ack network.
// Queues input spikes per channel, issues them round-robin as 4-phase handshakes, answers output requests.
//
// state | meaning
// IDLE  | no handshake in flight; arbiter may grant a channel with pending spikes
// REQ   | net_req_in[g] high, waiting for synchronized ack_in[g] to rise
// REL   | net_req_in low, waiting for synchronized ack_in[g] to fall
module spike_scheduler #(
    parameter int neurons_in  = 4,
    parameter int neurons_out = 2,
    parameter int cnt_w       = 4,
    parameter int sync_stages = 2,
    parameter int timeout     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [neurons_in-1:0]  spike_in,
    output logic [neurons_in-1:0]  net_req_in,
    input  logic [neurons_in-1:0]  net_ack_in,
    input  logic [neurons_out-1:0] net_req_out,
    output logic [neurons_out-1:0] net_ack_out,
    output logic [neurons_out-1:0] spike_out,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_overflow,
    input  logic                   clr_err
);

    localparam int idx_w = (neurons_in > 1) ? $clog2(neurons_in) : 1;
    localparam logic [cnt_w-1:0] cnt_max = {cnt_w{1'b1}};
    localparam logic [15:0] timer_last = 16'(timeout - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2} state_t;

    state_t                 state, state_next;
    logic [idx_w-1:0]       g, g_next, rr, grant_idx, cand_idx;
    logic                   grant, cnt_any, timer_done, to_set, ovf_set;
    logic [15:0]            timer;
    logic [cnt_w-1:0]       cnt [neurons_in];
    logic [cnt_w-1:0]       cnt_next [neurons_in];
    logic [neurons_in-1:0]  ack_sync [sync_stages];
    logic [neurons_out-1:0] req_sync [sync_stages];
    logic [neurons_in-1:0]  ack_s, req_next;
    logic [neurons_out-1:0] rs;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < sync_stages; k++) begin
                ack_sync[k] <= '0;
                req_sync[k] <= '0;
            end
        end else begin
            ack_sync[0] <= net_ack_in;
            req_sync[0] <= net_req_out;
            for (int k = 1; k < sync_stages; k++) begin
                ack_sync[k] <= ack_sync[k-1];
                req_sync[k] <= req_sync[k-1];
            end
        end
    end

    assign ack_s = ack_sync[sync_stages-1];
    assign rs    = req_sync[sync_stages-1];

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        cnt_any   = 1'b0;
        for (int i = 0; i < neurons_in; i++) begin
            if (cnt[i] != '0) cnt_any = 1'b1;
        end
        for (int k = 1; k <= neurons_in; k++) begin
            cand_idx = idx_w'((int'(rr) + k) % neurons_in);
            if (state == IDLE && !grant && cnt[cand_idx] != '0) begin
                grant     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        g_next     = g;
        to_set     = 1'b0;
        req_next   = '0;
        timer_done = (timer == timer_last);
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = REQ;
                    g_next     = grant_idx;
                end
            end
            REQ: begin
                if (ack_s[g]) begin
                    state_next = REL;
                end else if (timer_done) begin
                    state_next = REL;
                    to_set     = 1'b1;
                end
            end
            REL: begin
                if (!ack_s[g]) begin
                    state_next = IDLE;
                end else if (timer_done) begin
                    state_next = IDLE;
                    to_set     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == REQ) req_next[g_next] = 1'b1;
    end

    always_comb begin
        ovf_set = 1'b0;
        for (int i = 0; i < neurons_in; i++) begin
            cnt_next[i] = cnt[i];
            if (spike_in[i] && !(grant && grant_idx == idx_w'(i))) begin
                if (cnt[i] == cnt_max) ovf_set = 1'b1;
                else cnt_next[i] = cnt[i] + 1'b1;
            end else if (!spike_in[i] && grant && grant_idx == idx_w'(i)) begin
                cnt_next[i] = cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            g            <= '0;
            rr           <= idx_w'(neurons_in - 1);
            timer        <= '0;
            net_req_in   <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            for (int i = 0; i < neurons_in; i++) cnt[i] <= '0;
        end else begin
            state      <= state_next;
            g          <= g_next;
            if (grant) rr <= grant_idx;
            timer      <= (state_next != state || state == IDLE) ? 16'd0 : timer + 16'd1;
            net_req_in <= req_next;
            for (int i = 0; i < neurons_in; i++) cnt[i] <= cnt_next[i];
            // A set in the same cycle as clr_err keeps the flag high.
            err_timeout  <= to_set  | (err_timeout  & ~clr_err);
            err_overflow <= ovf_set | (err_overflow & ~clr_err);
        end
    end

    // ack simply follows the synchronized request; its rising edge marks one event.
    always_ff @(posedge clk) begin
        if (rst) begin
            net_ack_out <= '0;
            spike_out   <= '0;
        end else begin
            net_ack_out <= rs;
            spike_out   <= rs & ~net_ack_out;
        end
    end

    assign busy = (state != IDLE) || cnt_any;

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: network ack model, grant monitor, per-feature check tasks.
module tb_spike_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] spike_in = '0;
    logic [3:0] net_req_in;
    logic [3:0] net_ack_in;
    logic [1:0] net_req_out = '0;
    logic [1:0] net_ack_out;
    logic [1:0] spike_out;
    logic       busy, err_timeout, err_overflow;
    logic       clr_err = 1'b0;
    logic       ack_en = 1'b1;

    int checks = 0;
    int errors = 0;

    spike_scheduler #(.neurons_in(4), .neurons_out(2), .cnt_w(2), .sync_stages(2), .timeout(64)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .net_req_in(net_req_in),
        .net_ack_in(net_ack_in), .net_req_out(net_req_out), .net_ack_out(net_ack_out),
        .spike_out(spike_out), .busy(busy), .err_timeout(err_timeout),
        .err_overflow(err_overflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Network input model: ack follows req a few cycles later when enabled.
    logic [3:0] hist0 = '0, hist1 = '0;
    initial net_ack_in = '0;
    always @(negedge clk) begin
        if (rst) begin
            hist0      <= '0;
            hist1      <= '0;
            net_ack_in <= '0;
        end else begin
            hist0      <= net_req_in;
            hist1      <= hist0;
            net_ack_in <= ack_en ? hist1 : 4'b0000;
        end
    end

    int         grants [4];
    int         order [$];
    int         multihot, hi_len, last_len;
    int         spike_cnt [2];
    logic [3:0] prev_req = '0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) grants[i] = 0;
            order.delete();
            multihot = 0; hi_len = 0; last_len = 0;
            spike_cnt[0] = 0; spike_cnt[1] = 0;
            prev_req = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (net_req_in[i] && !prev_req[i]) begin
                    grants[i]++;
                    order.push_back(i);
                end
            end
            if ($countones(net_req_in) > 1) multihot++;
            if (net_req_in != 0) hi_len++;
            else if (hi_len != 0) begin
                last_len = hi_len;
                hi_len = 0;
            end
            for (int j = 0; j < 2; j++) if (spike_out[j]) spike_cnt[j]++;
            prev_req = net_req_in;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; spike_in = '0; clr_err = 1'b0; net_req_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string name);
        for (int n = 0; n < lim && busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, lim);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (net_req_in !== 4'b0000) begin errors++; $display("FAIL reset_req_in: got %b want 0000", net_req_in); end
        checks++; if (net_ack_out !== 2'b00) begin errors++; $display("FAIL reset_ack_out: got %b want 00", net_ack_out); end
        checks++; if (spike_out !== 2'b00) begin errors++; $display("FAIL reset_spike_out: got %b want 00", spike_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({err_timeout, err_overflow} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {err_timeout, err_overflow}); end
    endtask

    task automatic test_single();
        do_reset();
        spike_in = 4'b0100;
        @(negedge clk);
        spike_in = 4'b0000;
        checks++; if (net_req_in !== 4'b0000) begin errors++; $display("FAIL single_req_early: got %b want 0000", net_req_in); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (net_req_in !== 4'b0100) begin errors++; $display("FAIL single_req: got %b want 0100", net_req_in); end
        wait_idle(100, "single_idle");
        checks++; if (grants[2] !== 1 || order.size() !== 1) begin errors++; $display("FAIL single_grants: got ch2=%0d total=%0d want 1/1", grants[2], order.size()); end
        checks++; if ({err_timeout, err_overflow} !== 2'b00) begin errors++; $display("FAIL single_errs: got %b want 00", {err_timeout, err_overflow}); end
    endtask

    task automatic test_round_robin();
        do_reset();
        spike_in = 4'b1111;
        @(negedge clk);
        spike_in = 4'b0000;
        wait_idle(300, "rr_idle");
        checks++;
        if (order.size() !== 4 || order[0] !== 0 || order[1] !== 1 || order[2] !== 2 || order[3] !== 3) begin
            errors++;
            $display("FAIL rr_order: got size=%0d first=%0d,%0d,%0d,%0d want 0,1,2,3", order.size(),
                     order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1,
                     order.size() > 2 ? order[2] : -1, order.size() > 3 ? order[3] : -1);
        end
        spike_in = 4'b0010;
        @(negedge clk);
        spike_in = 4'b0000;
        wait_idle(100, "rr_wrap_idle");
        checks++; if (order.size() !== 5 || order[order.size()-1] !== 1) begin errors++; $display("FAIL rr_wrap: got size=%0d last=%0d want 5/1", order.size(), order[order.size()-1]); end
        checks++; if (multihot !== 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-bit cycles want 0", multihot); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        spike_in = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        spike_in = 4'b0000;
        checks++; if (net_req_in !== 4'b0010) begin errors++; $display("FAIL same_req: got %b want 0010", net_req_in); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy); end
        wait_idle(150, "same_idle");
        checks++; if (grants[1] !== 2) begin errors++; $display("FAIL same_grants: got %0d want 2", grants[1]); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL same_ovf: got %b want 0", err_overflow); end
    endtask

    task automatic test_overflow_timeout();
        ack_en = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            spike_in = 4'b0001;
            @(negedge clk);
        end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
        @(negedge clk);
        spike_in = 4'b0000;
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", err_overflow); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", err_timeout); end
        wait_idle(600, "to_idle");
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", err_timeout); end
        checks++; if (grants[0] !== 4) begin errors++; $display("FAIL to_drain: got %0d grants want 4", grants[0]); end
        checks++; if (last_len !== 64) begin errors++; $display("FAIL to_len: got req high %0d cycles want 64", last_len); end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if ({err_timeout, err_overflow} !== 2'b00) begin errors++; $display("FAIL clr_err: got %b want 00", {err_timeout, err_overflow}); end
        ack_en = 1'b1;
    endtask

    task automatic test_output();
        do_reset();
        net_req_out = 2'b10;
        @(negedge clk);
        @(negedge clk);
        checks++; if (net_ack_out !== 2'b00) begin errors++; $display("FAIL out_ack_early: got %b want 00", net_ack_out); end
        @(negedge clk);
        checks++; if (net_ack_out !== 2'b10 || spike_out !== 2'b10) begin errors++; $display("FAIL out_ack_rise: got ack=%b spike=%b want 10/10", net_ack_out, spike_out); end
        @(negedge clk);
        checks++; if (net_ack_out !== 2'b10 || spike_out !== 2'b00) begin errors++; $display("FAIL out_pulse_len: got ack=%b spike=%b want 10/00", net_ack_out, spike_out); end
        net_req_out = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (net_ack_out !== 2'b10) begin errors++; $display("FAIL out_ack_hold: got %b want 10", net_ack_out); end
        @(negedge clk);
        checks++; if (net_ack_out !== 2'b00) begin errors++; $display("FAIL out_ack_fall: got %b want 00", net_ack_out); end
        for (int e = 0; e < 2; e++) begin
            net_req_out = 2'b10;
            for (int n = 0; n < 10 && net_ack_out[1] !== 1'b1; n++) @(negedge clk);
            net_req_out = 2'b00;
            for (int n = 0; n < 10 && net_ack_out[1] !== 1'b0; n++) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++; if (spike_cnt[1] !== 3 || spike_cnt[0] !== 0) begin errors++; $display("FAIL out_pulses: got ch1=%0d ch0=%0d want 3/0", spike_cnt[1], spike_cnt[0]); end
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        do_reset();
        spike_in = 4'b1001;
        @(negedge clk);
        spike_in = 4'b0000;
        @(negedge clk);
        checks++; if (net_req_in !== 4'b0001) begin errors++; $display("FAIL mid_req: got %b want 0001", net_req_in); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (net_req_in !== 4'b0000) begin errors++; $display("FAIL mid_req_drop: got %b want 0000", net_req_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (net_req_in !== 4'b0000 || order.size() !== 0) begin errors++; $display("FAIL mid_no_grant: got req=%b grants=%0d want 0000/0", net_req_in, order.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_same_cycle();
        test_overflow_timeout();
        test_output();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
